pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and target addresses.
REQ-002 Parameter INC, default 1, PC increment per sequential fetch (power of two: 1 word-addressed, 4 byte-addressed).
REQ-003 Parameter RESET_VEC, default 0, PC value held during and directly after reset.
REQ-004 Parameter EXC_VEC, default 'h20, PC value loaded on exception redirect.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 stall_i  input  1  hold PC (downstream not accepting fetch).
REQ-008 branch_flag_i  input  1  branch redirect request, single-cycle pulse.
REQ-009 branch_target_addr_i  input  ADDR_W  branch target, sampled when branch_flag_i=1.
REQ-010 exc_flag_i  input  1  exception redirect request to EXC_VEC, single-cycle pulse.
REQ-011 pc_o  output  ADDR_W  current fetch address (registered).
REQ-012 ce_o  output  1  instruction memory chip enable (registered).
REQ-013 redirect_pending_o  output  1  a redirect is latched awaiting stall release.

Function
REQ-014 States SHALL be IDLE, RUN, HOLD; ce_o=0 in IDLE, 1 in RUN and HOLD.
REQ-015 IDLE SHALL hold pc_o=RESET_VEC, ignore all redirect/stall inputs, and go to RUN next cycle; first fetched address is RESET_VEC.
REQ-016 RUN, stall_i=0: priority exc_flag_i > branch_flag_i > increment; pc_o <= EXC_VEC, target, or pc_o+INC respectively.
REQ-017 Increment SHALL wrap modulo 2^ADDR_W (all-ones region +INC -> 0), no flag.
REQ-018 Loaded targets SHALL have the low log2(INC) bits forced to zero.
REQ-019 RUN, stall_i=1, no redirect: pc_o held, stay RUN.
REQ-020 RUN, stall_i=1 with redirect: pc_o held, redirect (exc wins if both) latched into pending register with kind bit, go HOLD.
REQ-021 HOLD, stall_i=1: pc_o held; new exc replaces any pending; new branch replaces pending branch only, never pending exc.
REQ-022 HOLD, stall_i=0: load pending target into pc_o, go RUN; a same-cycle exc overrides pending; a same-cycle branch overrides pending branch only.
REQ-023 redirect_pending_o SHALL equal 1 exactly while in HOLD.
REQ-024 Redirect latency: redirect in cycle N with stall_i=0 appears on pc_o in cycle N+1.

Reset
REQ-025 rst=1 at any clock edge, in any state, SHALL force IDLE, pc_o=RESET_VEC, ce_o=0, clear pending register and redirect_pending_o=0.
REQ-026 Redirects coincident with rst or presented in IDLE SHALL be discarded.

Structure
REQ-027 State encoding and ChipEnable/ChipDisable, JumpEnable constants SHALL live in the shared defines package; parameters stay per-instance.
REQ-028 Pending-redirect storage (target, kind, valid) SHALL be one sub-module redirect_buf; FSM and PC register stay in pc_gen.

Verification
REQ-029 rst high 3 cycles then low -> ce_o 0,0,0,0,1; pc_o RESET_VEC for first two post-reset cycles, then 1,2,3 (INC=1).
REQ-030 RUN at pc=5, branch_flag_i=1 target 'h40 -> next pc_o='h40, then 'h41.
REQ-031 stall_i=1 at pc=8, branch 'h80 pulse, stall 3 more cycles -> pc_o stays 8, redirect_pending_o=1, pc_o='h80 cycle after stall drops.
REQ-032 In HOLD with pending branch 'h80, exc_flag_i pulse, then branch 'hC0, stall release -> pc_o=EXC_VEC.
REQ-033 ADDR_W=8, INC=4, pc='hFC, no stall -> pc_o='h00; branch target 'h13 -> pc_o='h10.
REQ-034 rst asserted while in HOLD -> next cycle IDLE, pc_o=RESET_VEC, redirect_pending_o=0, pending target never loaded.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared definitions for the program-counter generator.
//   state_t      : fetch FSM state encoding (IDLE, RUN, HOLD)
//   ChipEnable / ChipDisable : instruction memory chip-enable levels
//   JumpEnable   : asserted level of the redirect request inputs
package pc_gen_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;
   localparam logic JumpEnable  = 1'b1;

endpackage

// File: rtl/redirect_buf.sv
// redirect_buf -- holds one redirect that arrived while fetch was stalled.
//   clk, rst        : clock, synchronous active-high reset
//   i_clr           : drop the pending entry (it has been consumed)
//   i_exc           : exception redirect to capture (always wins)
//   i_branch        : branch redirect to capture (never displaces an exception)
//   i_exc_addr      : aligned exception vector
//   i_branch_addr   : aligned branch target
//   o_valid         : an entry is pending
//   o_exc           : pending entry is an exception
//   o_target        : pending target address
module redirect_buf
   import pc_gen_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_exc,
   input  logic              i_branch,
   input  logic [ADDR_W-1:0] i_exc_addr,
   input  logic [ADDR_W-1:0] i_branch_addr,
   output logic              o_valid,
   output logic              o_exc,
   output logic [ADDR_W-1:0] o_target
);

   logic              r_valid;
   logic              r_exc;
   logic [ADDR_W-1:0] r_target;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_valid  <= 1'b0;
         r_exc    <= 1'b0;
         r_target <= '0;
      end else if (i_exc) begin
         r_valid  <= 1'b1;
         r_exc    <= 1'b1;
         r_target <= i_exc_addr;
      end else if (i_branch && !(r_valid && r_exc)) begin
         // a pending exception is sticky against later branches
         r_valid  <= 1'b1;
         r_exc    <= 1'b0;
         r_target <= i_branch_addr;
      end
   end

   assign o_valid  = r_valid;
   assign o_exc    = r_exc;
   assign o_target = r_target;

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- instruction fetch program-counter generator.
//   clk, rst              : clock, synchronous active-high reset
//   stall_i               : hold PC, downstream not accepting the fetch
//   branch_flag_i         : branch redirect pulse
//   branch_target_addr_i  : branch target, sampled with branch_flag_i
//   exc_flag_i            : exception redirect pulse (to EXC_VEC)
//   pc_o                  : current fetch address
//   ce_o                  : instruction memory chip enable
//   redirect_pending_o    : a redirect is waiting for the stall to drop
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                INC       = 1,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'('h20)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_addr_i,
   input  logic              exc_flag_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              ce_o,
   output logic              redirect_pending_o
);

   // INC is a power of two, so INC-1 covers exactly the sub-fetch bits
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC) - ADDR_W'(1));

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;

   logic              w_exc;
   logic              w_br;
   logic [ADDR_W-1:0] w_exc_addr;
   logic [ADDR_W-1:0] w_br_addr;
   logic              w_buf_exc;
   logic              w_buf_br;
   logic              w_buf_clr;
   logic              w_pend_valid;
   logic              w_pend_exc;
   logic [ADDR_W-1:0] w_pend_target;

   assign w_exc      = (exc_flag_i == JumpEnable);
   assign w_br       = (branch_flag_i == JumpEnable);
   assign w_exc_addr = EXC_VEC & ALIGN_MASK;
   assign w_br_addr  = branch_target_addr_i & ALIGN_MASK;

   redirect_buf #(.ADDR_W(ADDR_W)) u_redirect_buf (
      .clk           (clk),
      .rst           (rst),
      .i_clr         (w_buf_clr),
      .i_exc         (w_buf_exc),
      .i_branch      (w_buf_br),
      .i_exc_addr    (w_exc_addr),
      .i_branch_addr (w_br_addr),
      .o_valid       (w_pend_valid),
      .o_exc         (w_pend_exc),
      .o_target      (w_pend_target)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_VEC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_exc   = 1'b0;
      w_buf_br    = 1'b0;
      w_buf_clr   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // redirects and stall are ignored; first fetch is RESET_VEC
            w_state_nxt = S_RUN;
            w_pc_nxt    = RESET_VEC;
         end
         S_RUN: begin
            if (!stall_i) begin
               if (w_exc)     w_pc_nxt = w_exc_addr;
               else if (w_br) w_pc_nxt = w_br_addr;
               else           w_pc_nxt = r_pc + ADDR_W'(INC);
            end else if (w_exc || w_br) begin
               w_buf_exc   = w_exc;
               w_buf_br    = w_br;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (stall_i) begin
               w_buf_exc = w_exc;
               w_buf_br  = w_br;
            end else begin
               w_state_nxt = S_RUN;
               w_buf_clr   = 1'b1;
               // same-cycle requests follow the same precedence as the buffer
               if (w_exc)                     w_pc_nxt = w_exc_addr;
               else if (w_br && !w_pend_exc)  w_pc_nxt = w_br_addr;
               else if (w_pend_valid)         w_pc_nxt = w_pend_target;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign pc_o               = r_pc;
   assign ce_o               = (r_state == S_IDLE) ? ChipDisable : ChipEnable;
   assign redirect_pending_o = (r_state == S_HOLD);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst, stall, br, exc;
   logic [31:0] tgt;
   logic [31:0] pc;
   logic        ce, pend;

   logic        rst8, stall8, br8, exc8;
   logic [7:0]  tgt8;
   logic [7:0]  pc8;
   logic        ce8, pend8;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br),
      .branch_target_addr_i(tgt), .exc_flag_i(exc),
      .pc_o(pc), .ce_o(ce), .redirect_pending_o(pend)
   );

   pc_gen #(.ADDR_W(8), .INC(4), .RESET_VEC(8'h00), .EXC_VEC(8'h20)) dut8 (
      .clk(clk), .rst(rst8), .stall_i(stall8), .branch_flag_i(br8),
      .branch_target_addr_i(tgt8), .exc_flag_i(exc8),
      .pc_o(pc8), .ce_o(ce8), .redirect_pending_o(pend8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; br = 1'b0; exc = 1'b0; tgt = '0;
      rst8 = 1'b1; stall8 = 1'b0; br8 = 1'b0; exc8 = 1'b0; tgt8 = '0;

      // reset: three cycles high, then IDLE, then RUN from RESET_VEC
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_ce", 32'(ce), 32'd0);
         chk("rst_pc", pc, 32'd0);
         chk("rst_pend", 32'(pend), 32'd0);
      end
      rst = 1'b0;
      br = 1'b1; tgt = 32'h55;             // must be ignored in IDLE
      chk("idle_ce", 32'(ce), 32'd0);
      tick();
      br = 1'b0;
      chk("run_ce", 32'(ce), 32'd1);
      chk("run_pc0", pc, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("inc_pc", pc, 32'(i));
      end

      // branch at pc=5
      br = 1'b1; tgt = 32'h40;
      tick(); br = 1'b0;
      chk("br_pc", pc, 32'h40);
      tick();
      chk("br_inc", pc, 32'h41);

      // stall without redirect holds pc
      stall = 1'b1;
      tick();
      chk("stall_pc", pc, 32'h41);
      chk("stall_pend", 32'(pend), 32'd0);
      stall = 1'b0;

      // get to pc=8, then stalled branch to 'h80
      br = 1'b1; tgt = 32'h8;
      tick(); br = 1'b0;
      chk("to8", pc, 32'h8);
      stall = 1'b1; br = 1'b1; tgt = 32'h80;
      tick(); br = 1'b0;
      chk("hold_pc", pc, 32'h8);
      chk("hold_pend", 32'(pend), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_pc3", pc, 32'h8);
         chk("hold_pend3", 32'(pend), 32'd1);
      end
      stall = 1'b0;
      tick();
      chk("rel_pc", pc, 32'h80);
      chk("rel_pend", 32'(pend), 32'd0);
      tick();
      chk("rel_inc", pc, 32'h81);

      // pending branch, then exc, then branch 'hC0, release -> EXC_VEC
      stall = 1'b1; br = 1'b1; tgt = 32'h80;
      tick(); br = 1'b0;
      exc = 1'b1;
      tick(); exc = 1'b0;
      br = 1'b1; tgt = 32'hC0;
      tick(); br = 1'b0;
      chk("exc_sticky_pc", pc, 32'h81);
      stall = 1'b0;
      tick();
      chk("exc_win", pc, 32'h20);

      // release with same-cycle branch overriding a pending branch
      stall = 1'b1; br = 1'b1; tgt = 32'h80;
      tick();
      stall = 1'b0; tgt = 32'h90;
      tick(); br = 1'b0;
      chk("br_override", pc, 32'h90);

      // exc beats branch in RUN
      exc = 1'b1; br = 1'b1; tgt = 32'h44;
      tick(); exc = 1'b0; br = 1'b0;
      chk("exc_prio", pc, 32'h20);

      // 32-bit wrap
      br = 1'b1; tgt = 32'hFFFF_FFFF;
      tick(); br = 1'b0;
      chk("wrap_top", pc, 32'hFFFF_FFFF);
      tick();
      chk("wrap_zero", pc, 32'h0);

      // reset while in HOLD discards the pending target
      stall = 1'b1; br = 1'b1; tgt = 32'h80;
      tick(); br = 1'b0;
      chk("pre_rst_pend", 32'(pend), 32'd1);
      rst = 1'b1;
      tick();
      chk("hrst_ce", 32'(ce), 32'd0);
      chk("hrst_pc", pc, 32'd0);
      chk("hrst_pend", 32'(pend), 32'd0);
      rst = 1'b0; stall = 1'b0;
      tick();
      chk("hrst_run", pc, 32'd0);
      tick();
      chk("hrst_inc", pc, 32'd1);

      // byte-addressed instance: wrap at 'hFC and target alignment
      rst8 = 1'b0;
      tick();
      chk("b8_ce", 32'(ce8), 32'd1);
      chk("b8_pc0", 32'(pc8), 32'h00);
      br8 = 1'b1; tgt8 = 8'hFC;
      tick(); br8 = 1'b0;
      chk("b8_fc", 32'(pc8), 32'hFC);
      tick();
      chk("b8_wrap", 32'(pc8), 32'h00);
      br8 = 1'b1; tgt8 = 8'h13;
      tick(); br8 = 1'b0;
      chk("b8_align", 32'(pc8), 32'h10);
      tick();
      chk("b8_inc", 32'(pc8), 32'h14);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
